// File: rtl/display_scan.sv
// display_scan: time-multiplexed multi-digit scanner feeding a shared
// BCD-to-7-segment decoder. Per-digit codes are double-buffered (shadow ->
// disp) and committed only at frame boundaries. Each digit slot opens with
// a short blanking gap to suppress ghosting.

// One digit lane: capture register plus displayed register.
module display_scan_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       commit,
    input  logic [3:0] din,
    output logic [3:0] disp
);
    logic [3:0] shadow;

    // Capture on load; on commit take din directly if it arrives on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= 4'd0;
            disp   <= 4'd0;
        end else begin
            if (load)   shadow <= din;
            if (commit) disp   <= load ? din : shadow;
        end
    end
endmodule

module display_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int BLANK  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  blank,
    output logic                  frame
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);

    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;
    logic                     pending;
    logic [DIGITS-1:0][3:0]   disp;
    logic [DIGITS-1:0][3:0]   din_v;
    logic                     slot_end;
    logic                     last_dig;
    logic                     boundary;
    logic                     commit;
    logic                     in_blank;

    assign din_v    = din;
    assign slot_end = (cnt == CW'(DIV - 1));
    assign last_dig = (idx == IW'(DIGITS - 1));
    assign boundary = en & slot_end & last_dig;
    assign commit   = boundary & (pending | load);

    // Blanking window at the start of each slot; vanishes entirely when BLANK=0.
    generate
        if (BLANK > 0) begin : g_blank
            assign in_blank = (cnt < CW'(BLANK));
        end else begin : g_noblank
            assign in_blank = 1'b0;
        end
    endgenerate

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_dig
            display_scan_digit u_dig (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (load),
                .commit (commit),
                .din    (din_v[k]),
                .disp   (disp[k])
            );
        end
    endgenerate

    // Slot prescaler and digit index; disabling parks both at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= last_dig ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Pending flag: a load on the boundary edge is committed at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pending <= 1'b0;
        else if (boundary) pending <= 1'b0;
        else if (load)     pending <= 1'b1;
    end

    // Registered outputs derived from the current slot position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd    <= 4'd0;
            dig_en <= '0;
            blank  <= 1'b1;
            frame  <= 1'b0;
        end else begin
            frame <= boundary;
            if (!en || in_blank) begin
                dig_en <= '0;
                blank  <= 1'b1;
            end else begin
                dig_en <= DIGITS'(1) << idx;
                blank  <= 1'b0;
                bcd    <= disp[idx];
            end
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: two instances (DIV=4/BLANK=1 and DIV=2/BLANK=0),
// each tracked by an arithmetic model of scan position, plus literal pins.
module tb_display_scan;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0, load  = 1'b0;
    logic [15:0] din   = 16'h0;
    logic        enb   = 1'b0, loadb = 1'b0;
    logic [15:0] dinb  = 16'h0;
    logic [3:0]  bcd, dig_en, bcdb, dig_enb;
    logic        blank, frame, blankb, frameb;

    int checks = 0;
    int errors = 0;
    int now    = 0;

    always #5 clk = ~clk;

    display_scan #(.DIGITS(4), .DIV(4), .BLANK(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din),
        .bcd(bcd), .dig_en(dig_en), .blank(blank), .frame(frame));

    display_scan #(.DIGITS(4), .DIV(2), .BLANK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(enb), .load(loadb), .din(dinb),
        .bcd(bcdb), .dig_en(dig_enb), .blank(blankb), .frame(frameb));

    // Model: p counts enabled cycles since scan start; slot/offset follow by division.
    typedef struct {
        int          p;
        logic [15:0] disp;
        logic [15:0] shadow;
        bit          pending;
        logic [3:0]  bcd;
        logic [3:0]  dig_en;
        bit          blank;
        bit          frame;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t r;
        r.p = 0; r.disp = '0; r.shadow = '0; r.pending = 0;
        r.bcd = '0; r.dig_en = '0; r.blank = 1; r.frame = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit e, bit ld, logic [15:0] d, int div, int bl);
        mdl_t n = m;
        bit   last = 0;
        int   slot, off;
        if (!e) begin
            n.p = 0; n.blank = 1; n.dig_en = '0; n.frame = 0;
        end else begin
            slot = (m.p / div) % 4;
            off  = m.p % div;
            last = (off == div - 1) && (slot == 3);
            if (off < bl) begin
                n.blank = 1; n.dig_en = '0;
            end else begin
                n.blank = 0; n.dig_en = 4'(1 << slot); n.bcd = m.disp[slot*4 +: 4];
            end
            n.frame = last;
            n.p = m.p + 1;
            if (last && ld) begin
                n.disp = d; n.pending = 0;
            end else if (last && m.pending) begin
                n.disp = m.shadow; n.pending = 0;
            end
        end
        if (ld) begin
            n.shadow = d;
            if (!last) n.pending = 1;
        end
        return n;
    endfunction

    mdl_t ma, mb;

    // Advance both models on every clock, clearing with the async reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, en,  load,  din,  4, 1);
            mb <= mstep(mb, enb, loadb, dinb, 2, 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the models, away from the active edge.
    always @(negedge clk) begin
        chk("a_bcd",    32'(bcd),     32'(ma.bcd));
        chk("a_dig_en", 32'(dig_en),  32'(ma.dig_en));
        chk("a_blank",  32'(blank),   32'(ma.blank));
        chk("a_frame",  32'(frame),   32'(ma.frame));
        chk("b_bcd",    32'(bcdb),    32'(mb.bcd));
        chk("b_dig_en", 32'(dig_enb), 32'(mb.dig_en));
        chk("b_blank",  32'(blankb),  32'(mb.blank));
        chk("b_frame",  32'(frameb),  32'(mb.frame));
    end

    task automatic upto(input int k);
        repeat (k - now) @(negedge clk);
        now = k;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_bcd",    32'(bcd),    32'h0);
        chk("rst_dig_en", 32'(dig_en), 32'h0);
        chk("rst_blank",  32'(blank),  32'h1);
        chk("rst_frame",  32'(frame),  32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) en = 1'b1;
        now = 0;

        // Idle scan of zeros.
        upto(1);  chk("lit_blank1", 32'(blank), 32'h1); chk("lit_den1", 32'(dig_en), 32'h0);
        upto(2);  chk("lit_den2", 32'(dig_en), 32'h1);  chk("lit_bcd2", 32'(bcd), 32'h0);
        // Load mid-slot of digit 1; current frame keeps showing 0.
        upto(6);  load = 1'b1; din = 16'h4321;
        upto(7);  load = 1'b0;
        upto(16); chk("lit_frame16", 32'(frame), 32'h1); chk("lit_den16", 32'(dig_en), 32'h8);
                  chk("lit_old16", 32'(bcd), 32'h0);
        upto(17); chk("lit_frame17", 32'(frame), 32'h0);
        upto(18); chk("lit_d0", 32'(bcd), 32'h1);
        upto(22); chk("lit_d1", 32'(bcd), 32'h2);
        upto(26); chk("lit_d2", 32'(bcd), 32'h3);
        upto(30); chk("lit_d3", 32'(bcd), 32'h4); chk("lit_den30", 32'(dig_en), 32'h8);
        // Load on the boundary edge, then another one cycle later.
        upto(31); load = 1'b1; din = 16'h9999;
        upto(32); din = 16'h5555;
        upto(33); load = 1'b0;
        upto(34); chk("lit_nine_a", 32'(bcd), 32'h9);
        upto(46); chk("lit_nine_b", 32'(bcd), 32'h9);
        upto(50); chk("lit_five_a", 32'(bcd), 32'h5);
        upto(62); chk("lit_five_b", 32'(bcd), 32'h5);
        // Drop enable for three cycles during digit 2.
        upto(74); chk("lit_den74", 32'(dig_en), 32'h4); en = 1'b0;
        upto(75); chk("lit_off_den", 32'(dig_en), 32'h0); chk("lit_off_blank", 32'(blank), 32'h1);
        upto(77); en = 1'b1;
        upto(78); chk("lit_re_blank", 32'(blank), 32'h1);
        upto(79); chk("lit_re_den", 32'(dig_en), 32'h1); chk("lit_re_bcd", 32'(bcd), 32'h5);
        // Async reset mid-slot with a capture pending.
        upto(85); load = 1'b1; din = 16'h7777;
        upto(86); load = 1'b0;
        upto(88); chk("lit_den88", 32'(dig_en), 32'h4);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_bcd",    32'(bcd),    32'h0);
        chk("arst_dig_en", 32'(dig_en), 32'h0);
        chk("arst_blank",  32'(blank),  32'h1);
        chk("arst_frame",  32'(frame),  32'h0);
        upto(89); rst_n = 1'b1;
        upto(107); chk("lit_post_bcd", 32'(bcd), 32'h0); chk("lit_post_den", 32'(dig_en), 32'h1);

        // Instance B: no blanking, two-cycle slots, hex codes.
        loadb = 1'b1; dinb = 16'hFEDC;
        @(negedge clk) loadb = 1'b0; enb = 1'b1;
        now = 0;
        upto(1);  chk("b_lit_blank1", 32'(blankb), 32'h0); chk("b_lit_den1", 32'(dig_enb), 32'h1);
                  chk("b_lit_bcd1", 32'(bcdb), 32'h0);
        upto(9);  chk("b_lit_c", 32'(bcdb), 32'hC); chk("b_lit_den9",  32'(dig_enb), 32'h1);
        upto(11); chk("b_lit_d", 32'(bcdb), 32'hD); chk("b_lit_den11", 32'(dig_enb), 32'h2);
        upto(13); chk("b_lit_e", 32'(bcdb), 32'hE); chk("b_lit_den13", 32'(dig_enb), 32'h4);
        upto(15); chk("b_lit_f", 32'(bcdb), 32'hF); chk("b_lit_den15", 32'(dig_enb), 32'h8);
        upto(16); chk("b_lit_frame", 32'(frameb), 32'h1); chk("b_lit_blank16", 32'(blankb), 32'h0);
        upto(24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
